// File: rtl/regfile_writer_if.sv
// regfile_writer_if: result offers, issue/decode ports and register-file write port
interface regfile_writer_if #(
  parameter int NUM_REGS  = 32,
  parameter int WIDTH     = 32,
  parameter int REG_WIDTH = 5
);
  logic                 issue_valid;
  logic [REG_WIDTH-1:0] issue_rd;
  logic                 alu_valid;
  logic [REG_WIDTH-1:0] alu_rd;
  logic [WIDTH-1:0]     alu_val;
  logic                 ld_valid;
  logic [REG_WIDTH-1:0] ld_rd;
  logic [WIDTH-1:0]     ld_val;
  logic                 in_ready;
  logic                 we;
  logic [REG_WIDTH-1:0] rdIn;
  logic [WIDTH-1:0]     dVal;
  logic [REG_WIDTH-1:0] rs_chk;
  logic [REG_WIDTH-1:0] rt_chk;
  logic                 stall;
  logic [NUM_REGS-1:0]  busy;
  logic                 overflow;
  modport master (
    output issue_valid, issue_rd, alu_valid, alu_rd, alu_val, ld_valid, ld_rd, ld_val, rs_chk, rt_chk,
    input  in_ready, we, rdIn, dVal, stall, busy, overflow
  );
  modport slave (
    input  issue_valid, issue_rd, alu_valid, alu_rd, alu_val, ld_valid, ld_rd, ld_val, rs_chk, rt_chk,
    output in_ready, we, rdIn, dVal, stall, busy, overflow
  );
endinterface

// File: rtl/regfile_writer.sv
// regfile_writer: queues ALU/load results into a single register-file write port
// and keeps a per-register busy scoreboard for decode-stage stalls.
module regfile_writer #(
  parameter int NUM_REGS  = 32,
  parameter int WIDTH     = 32,
  parameter int REG_WIDTH = 5,
  parameter int DEPTH     = 4
) (
  input logic clock,
  input logic reset_n,
  regfile_writer_if.slave bus
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [REG_WIDTH-1:0] q_rd [DEPTH];
  logic [WIDTH-1:0]     q_val [DEPTH];
  logic [PW-1:0]        wp, rp;
  logic [CW-1:0]        count;
  logic                 wr_en, overflow;
  logic [REG_WIDTH-1:0] wr_rd;
  logic [WIDTH-1:0]     wr_val;
  logic [NUM_REGS-1:0]  busy, set_m, clr_m, busy_nxt;
  logic                 ld_ok, alu_ok, ld_go, alu_go, pop, drop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign ld_ok    = bus.ld_valid && bus.ld_rd != '0;
  assign alu_ok   = bus.alu_valid && bus.alu_rd != '0;
  assign bus.in_ready = count <= CW'(DEPTH - 2);
  assign ld_go    = ld_ok && bus.in_ready;
  assign alu_go   = alu_ok && bus.in_ready;
  assign drop     = (ld_ok || alu_ok) && !bus.in_ready;
  assign pop      = count != '0;

  // a clear and a set of the same register at one edge leaves it set
  assign set_m    = (bus.issue_valid && bus.issue_rd != '0) ? NUM_REGS'(1) << bus.issue_rd : '0;
  assign clr_m    = wr_en ? NUM_REGS'(1) << wr_rd : '0;
  assign busy_nxt = ((busy & ~clr_m) | set_m) & ~NUM_REGS'(1);

  always_ff @(posedge clock) begin
    if (ld_go) begin
      q_rd[wp]  <= bus.ld_rd;
      q_val[wp] <= bus.ld_val;
    end
    if (alu_go) begin
      q_rd[ld_go ? nxt(wp) : wp]  <= bus.alu_rd;
      q_val[ld_go ? nxt(wp) : wp] <= bus.alu_val;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wp       <= '0;
      rp       <= '0;
      count    <= '0;
      wr_en    <= 1'b0;
      wr_rd    <= '0;
      wr_val   <= '0;
      busy     <= '0;
      overflow <= 1'b0;
    end else begin
      wp       <= (ld_go && alu_go) ? nxt(nxt(wp)) : (ld_go || alu_go) ? nxt(wp) : wp;
      rp       <= pop ? nxt(rp) : rp;
      count    <= count + CW'(ld_go) + CW'(alu_go) - CW'(pop);
      wr_en    <= pop;
      wr_rd    <= pop ? q_rd[rp] : wr_rd;
      wr_val   <= pop ? q_val[rp] : wr_val;
      busy     <= busy_nxt;
      overflow <= overflow | drop;
    end
  end

  assign bus.we       = wr_en;
  assign bus.rdIn     = wr_rd;
  assign bus.dVal     = wr_val;
  assign bus.busy     = busy;
  assign bus.overflow = overflow;
  assign bus.stall    = busy[bus.rs_chk] | busy[bus.rt_chk];
endmodule

// File: tb/tb_regfile_writer.sv
// tb_regfile_writer: directed stimulus with a write-port scoreboard and monitor
module tb_regfile_writer;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int total = 0;
  int passed = 0;
  logic [36:0] exp_q [$];

  regfile_writer_if bus ();
  regfile_writer dut (.clock(clock), .reset_n(reset_n), .bus(bus.slave));

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, want);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.issue_valid = 0; bus.alu_valid = 0; bus.ld_valid = 0;
  endtask

  task automatic alu(input logic [4:0] rd, input logic [31:0] v);
    bus.alu_valid = 1; bus.alu_rd = rd; bus.alu_val = v;
  endtask

  task automatic ld(input logic [4:0] rd, input logic [31:0] v);
    bus.ld_valid = 1; bus.ld_rd = rd; bus.ld_val = v;
  endtask

  always @(negedge clock) begin
    if (bus.we) begin
      total++;
      if (exp_q.size() == 0)
        $display("FAIL unexpected_write: got rd=%0d val=%0h expected no write", bus.rdIn, bus.dVal);
      else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        if ({bus.rdIn, bus.dVal} === e) passed++;
        else $display("FAIL write: got rd=%0d val=%0h expected rd=%0d val=%0h",
                      bus.rdIn, bus.dVal, e[36:32], e[31:0]);
      end
    end
  end

  initial begin
    idle();
    bus.issue_rd = 0; bus.alu_rd = 0; bus.alu_val = 0; bus.ld_rd = 0; bus.ld_val = 0;
    bus.rs_chk = 0; bus.rt_chk = 0;
    #3;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_we", bus.we, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_overflow", bus.overflow, 0);
    chk("rst_stall", bus.stall, 0);
    step(); step();
    reset_n = 1;
    // single result
    bus.issue_valid = 1; bus.issue_rd = 5;
    step();
    idle(); alu(5, 32'hDEAD); exp_q.push_back({5'd5, 32'hDEAD});
    bus.rs_chk = 5; #1;
    chk("busy5_set", bus.busy[5], 1);
    chk("stall_rs5", bus.stall, 1);
    step(); idle();
    step();
    chk("busy5_during_we", bus.busy[5], 1);
    step();
    chk("busy5_cleared", bus.busy[5], 0);
    chk("stall_cleared", bus.stall, 0);
    // simultaneous results, load first
    ld(3, 32'h11); alu(4, 32'h22);
    exp_q.push_back({5'd3, 32'h11}); exp_q.push_back({5'd4, 32'h22});
    step(); idle();
    repeat (4) step();
    // rd 0 is discarded silently
    alu(0, 32'hFF);
    step(); idle();
    repeat (3) step();
    chk("rd0_busy", bus.busy, 0);
    chk("rd0_overflow", bus.overflow, 0);
    // set/clear collision on r7
    alu(7, 32'h77); exp_q.push_back({5'd7, 32'h77});
    step(); idle();
    step();
    chk("collide_we", bus.we, 1);
    bus.issue_valid = 1; bus.issue_rd = 7;
    step(); idle();
    chk("collide_busy7", bus.busy[7], 1);
    repeat (2) step();
    // fill to three entries, then offer two results that must drop
    ld(10, 32'hA1); alu(11, 32'hA2);
    exp_q.push_back({5'd10, 32'hA1}); exp_q.push_back({5'd11, 32'hA2});
    step();
    chk("fill_ready_cnt2", bus.in_ready, 1);
    ld(12, 32'hA3); alu(13, 32'hA4);
    exp_q.push_back({5'd12, 32'hA3}); exp_q.push_back({5'd13, 32'hA4});
    step();
    chk("fill_ready_cnt3", bus.in_ready, 0);
    ld(14, 32'hA5); alu(15, 32'hA6);
    step(); idle();
    chk("overflow_set", bus.overflow, 1);
    repeat (6) step();
    chk("overflow_sticky", bus.overflow, 1);
    chk("drain_ready", bus.in_ready, 1);
    // reset with three entries queued
    ld(20, 32'hB1); alu(21, 32'hB2);
    step();
    ld(22, 32'hB3); alu(23, 32'hB4);
    step(); idle();
    bus.rs_chk = 7;
    reset_n = 0;
    exp_q.delete();
    #1;
    chk("midrst_we", bus.we, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_ready", bus.in_ready, 1);
    chk("midrst_overflow", bus.overflow, 0);
    chk("midrst_stall", bus.stall, 0);
    step(); step();
    reset_n = 1;
    repeat (5) step();
    alu(9, 32'h99); exp_q.push_back({5'd9, 32'h99});
    step(); idle();
    repeat (4) step();
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/regfile_writer.md
REGFILE_WRITER -- requirements
Module: regfile_writer

Interface
REQ-001 Parameters SHALL be: NUM_REGS, 32, number of architectural registers; WIDTH, 32, data width; REG_WIDTH, 5, register index width; DEPTH, 4, write-queue entries.
REQ-002 Clocking SHALL be one clock; reset is asynchronous and active-low.
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 issue_valid, issue_rd  input  1, REG_WIDTH  instruction issued that will write issue_rd.
REQ-006 alu_valid, alu_rd, alu_val  input  1, REG_WIDTH, WIDTH  ALU result offered.
REQ-007 ld_valid, ld_rd, ld_val  input  1, REG_WIDTH, WIDTH  load result offered.
REQ-008 in_ready  output  1  queue can accept two results this cycle.
REQ-009 we, rdIn, dVal  output  1, REG_WIDTH, WIDTH  registered write port driving the register file.
REQ-010 rs_chk, rt_chk  input  REG_WIDTH each  decode-stage source indices.
REQ-011 stall  output  1  combinational: busy[rs_chk] OR busy[rt_chk].
REQ-012 busy  output  NUM_REGS  scoreboard, one bit per register.
REQ-013 overflow  output  1  sticky: a result was dropped.

Function
REQ-014 Queue SHALL be a DEPTH-entry FIFO of {rd, val}, with a count 0..DEPTH and wrapping read/write pointers.
REQ-015 in_ready SHALL be 1 iff count <= DEPTH-2.
REQ-016 A valid result with rd == 0 SHALL be discarded: not enqueued, no overflow.
REQ-017 When both results are valid in the same cycle, ld SHALL be enqueued before alu; both in one edge.
REQ-018 Results presented while in_ready == 0 SHALL be dropped and SHALL set overflow.
REQ-019 Each cycle with count > 0 SHALL pop the head; at that edge we <= 1, rdIn <= head.rd, dVal <= head.val; otherwise we <= 0 and rdIn/dVal hold.
REQ-020 Push and pop in the same cycle SHALL leave count unchanged, net of pushes; a push into an empty queue is not popped until the following cycle.
REQ-021 Latency SHALL be 2 edges: accepted at edge N, we high during cycle N+1 to N+2, with the register-file write at edge N+2.
REQ-022 Writes SHALL leave in acceptance order.
REQ-023 issue_valid with issue_rd != 0 SHALL set busy[issue_rd] at the edge; issue_rd == 0 has no effect; busy[0] is constantly 0.
REQ-024 At an edge where we == 1, busy[rdIn] SHALL clear, coinciding with the register-file write.
REQ-025 A set and a clear of the same register at the same edge SHALL leave the bit set.
REQ-026 stall SHALL be purely combinational from busy, rs_chk and rt_chk.

Reset
REQ-027 reset_n low SHALL immediately force:
- count = 0 and pointers = 0;
- we = 0, rdIn = 0, dVal = 0;
- busy = 0 and overflow = 0;
- in_ready = 1 and stall = 0.
REQ-028 Reset mid-operation SHALL discard queued entries; no write may occur after reset_n deasserts until new results are accepted.
REQ-029 overflow SHALL clear only on reset.

Verification
REQ-030 Single result: issue rd=5; next cycle alu rd=5 val=0xDEAD -> busy[5]=1 and stall with rs_chk=5; we=1/rdIn=5/dVal=0xDEAD one cycle later; busy[5]=0 after that edge.
REQ-031 Simultaneous results: ld rd=3 val=0x11 and alu rd=4 val=0x22 in one cycle -> writes on consecutive cycles, rd=3 first, then rd=4.
REQ-032 Fill queue: two-result bursts with no drain are impossible, since the queue pops one per cycle -> hold in_ready with count=3 and present two results -> both dropped, overflow=1, queue unchanged.
REQ-033 rd=0: alu rd=0 val=0xFF -> no we pulse, busy stays 0, overflow=0.
REQ-034 Set/clear collision: we=1 rdIn=7 at the same edge as issue rd=7 -> busy[7]=1 afterwards.
REQ-035 Reset mid-operation: queue holding 3 entries, assert reset_n=0 -> we=0, busy=0, count=0 immediately; after release no we until a new result arrives.
